// File: rtl/audio_xfer_sched_if.sv
// Stream and Avalon-MM signal bundle for audio_xfer_sched.
// master: the scheduler side; slave: the environment (source, sink, audio core).
interface audio_xfer_sched_if;
  logic        play_valid;
  logic [31:0] play_data;
  logic        play_ready;
  logic        rec_valid;
  logic [31:0] rec_data;
  logic        rec_ready;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    input  play_valid, play_data, rec_ready, avm_readdata, avm_waitrequest,
    output play_ready, rec_valid, rec_data, avm_address, avm_read, avm_write,
           avm_writedata
  );

  modport slave (
    output play_valid, play_data, rec_ready, avm_readdata, avm_waitrequest,
    input  play_ready, rec_valid, rec_data, avm_address, avm_read, avm_write,
           avm_writedata
  );
endinterface

// File: rtl/audio_xfer_sched.sv
// Audio transfer scheduler: moves stereo pairs between a playback stream and
// the audio core's left/right data registers, and from those registers to a
// record stream, arbitrating round-robin between the two directions.
module audio_xfer_sched #(
  parameter int unsigned ADDR_LEFT  = 2,
  parameter int unsigned ADDR_RIGHT = 3,
  parameter int unsigned MIN_SPACE  = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [15:0]               space_in,
  audio_xfer_sched_if.master        bus,
  output logic [15:0]               play_count,
  output logic [15:0]               rec_count,
  output logic                      busy
);

  localparam logic [1:0] ADDR_L = 2'(ADDR_LEFT);
  localparam logic [1:0] ADDR_R = 2'(ADDR_RIGHT);
  localparam logic [7:0] MIN_B  = 8'(MIN_SPACE);

  typedef enum logic [2:0] {IDLE, WL, WR, RL, RLD, RR, RRD} state_t;

  state_t      state_q, state_d;
  logic        last_rec_q, last_rec_d;
  logic [31:0] play_buf_q, play_buf_d;
  logic [15:0] left_q, left_d;
  logic        rec_valid_q, rec_valid_d;
  logic [31:0] rec_data_q, rec_data_d;
  logic [15:0] play_count_q, play_count_d;
  logic [15:0] rec_count_q, rec_count_d;

  logic play_elig, rec_elig, grant_play, grant_rec;

  // The upper read half carries no sample data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^bus.avm_readdata[31:16];

  // Eligibility and round-robin grant; only acted upon in IDLE, so space_in
  // has no effect once a pair is under way.
  always_comb begin
    play_elig  = enable && bus.play_valid && (space_in[15:8] >= MIN_B);
    rec_elig   = enable && (space_in[7:0] >= MIN_B) && !rec_valid_q;
    grant_play = play_elig && (!rec_elig || last_rec_q);
    grant_rec  = rec_elig && !grant_play;
  end

  // Next-state and bus outputs; strobes decode from state alone so address
  // and data hold steady for as long as waitrequest stalls a cycle.
  always_comb begin
    state_d           = state_q;
    last_rec_d        = last_rec_q;
    play_buf_d        = play_buf_q;
    left_d            = left_q;
    rec_valid_d       = rec_valid_q;
    rec_data_d        = rec_data_q;
    play_count_d      = play_count_q;
    rec_count_d       = rec_count_q;
    bus.avm_read      = 1'b0;
    bus.avm_write     = 1'b0;
    bus.avm_address   = '0;
    bus.avm_writedata = '0;
    bus.play_ready    = 1'b0;

    if (rec_valid_q && bus.rec_ready) rec_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_play) begin
          play_buf_d = bus.play_data;
          last_rec_d = 1'b0;
          state_d    = WL;
        end else if (grant_rec) begin
          last_rec_d = 1'b1;
          state_d    = RL;
        end
      end
      WL: begin
        bus.avm_write     = 1'b1;
        bus.avm_address   = ADDR_L;
        bus.avm_writedata = {16'h0000, play_buf_q[31:16]};
        if (!bus.avm_waitrequest) state_d = WR;
      end
      WR: begin
        bus.avm_write     = 1'b1;
        bus.avm_address   = ADDR_R;
        bus.avm_writedata = {16'h0000, play_buf_q[15:0]};
        if (!bus.avm_waitrequest) begin
          bus.play_ready = 1'b1;
          play_count_d   = play_count_q + 16'd1;
          state_d        = IDLE;
        end
      end
      RL: begin
        bus.avm_read    = 1'b1;
        bus.avm_address = ADDR_L;
        if (!bus.avm_waitrequest) state_d = RLD;
      end
      RLD: begin
        left_d  = bus.avm_readdata[15:0];
        state_d = RR;
      end
      RR: begin
        bus.avm_read    = 1'b1;
        bus.avm_address = ADDR_R;
        if (!bus.avm_waitrequest) state_d = RRD;
      end
      RRD: begin
        rec_data_d  = {left_q, bus.avm_readdata[15:0]};
        rec_valid_d = 1'b1;
        rec_count_d = rec_count_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_rec_q   <= 1'b1;
      play_buf_q   <= '0;
      left_q       <= '0;
      rec_valid_q  <= 1'b0;
      rec_data_q   <= '0;
      play_count_q <= '0;
      rec_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_rec_q   <= last_rec_d;
      play_buf_q   <= play_buf_d;
      left_q       <= left_d;
      rec_valid_q  <= rec_valid_d;
      rec_data_q   <= rec_data_d;
      play_count_q <= play_count_d;
      rec_count_q  <= rec_count_d;
    end
  end

  assign bus.rec_valid = rec_valid_q;
  assign bus.rec_data  = rec_data_q;
  assign play_count    = play_count_q;
  assign rec_count     = rec_count_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_audio_xfer_sched.sv
// Self-checking bench for audio_xfer_sched: eligibility table, directed
// corner-case sequences, and a randomized run against a transaction model.
module tb_audio_xfer_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] space_in;
  logic [15:0] play_count;
  logic [15:0] rec_count;
  logic        busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  audio_xfer_sched_if bus ();

  audio_xfer_sched #(.ADDR_LEFT(2), .ADDR_RIGHT(3), .MIN_SPACE(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .space_in   (space_in),
    .bus        (bus),
    .play_count (play_count),
    .rec_count  (rec_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       pv;
    logic [7:0] ws;
    logic [7:0] ra;
    logic       exp_busy;
    logic       exp_w;
    logic       exp_r;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    enable              = 1'b0;
    space_in            = 16'h0000;
    bus.play_valid      = 1'b0;
    bus.play_data       = 32'h0;
    bus.rec_ready       = 1'b0;
    bus.avm_readdata    = 32'h0;
    bus.avm_waitrequest = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          grants[$];
    bit          prev_busy;
    logic [31:0] pair_q[$];
    logic [31:0] rd_next;
    logic [15:0] left_tmp;
    logic [31:0] exp_pair;
    bit          rd_pend, w_half, r_half, last_rec, play_taken, pe, re;
    int unsigned exp_g;
    int unsigned plays_done, recs_done;

    // en, pv, wspace, ravail -> busy, first op write, first op read (one cycle after reset)
    vecs[0] = '{1'b0, 1'b1, 8'd4,   8'd4,   1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'd4,   8'd0,   1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'd4,   8'd3,   1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'd0,   8'd1,   1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'd1,   8'd1,   1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'd255, 8'd255, 1'b1, 1'b1, 1'b0};

    reset_n = 1'b0;
    idle_inputs();

    // ---------------- table-driven eligibility / first grant ----------------
    foreach (vecs[i]) begin
      do_reset();
      enable         = vecs[i].en;
      bus.play_valid = vecs[i].pv;
      bus.play_data  = $urandom();
      space_in       = {vecs[i].ws, vecs[i].ra};
      sample();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rec_valid", 32'(bus.rec_valid), 32'd0);
      chk("reset_counts", {play_count, rec_count}, 32'd0);
      tick();
      sample();
      chk("tbl_busy", 32'(busy), 32'(vecs[i].exp_busy));
      chk("tbl_write", 32'(bus.avm_write), 32'(vecs[i].exp_w));
      chk("tbl_read", 32'(bus.avm_read), 32'(vecs[i].exp_r));
    end

    // ---------------- playback pair, no wait states ----------------
    do_reset();
    enable = 1'b1; bus.play_valid = 1'b1; bus.play_data = 32'h1234ABCD; space_in = 16'h0400;
    sample();
    chk("p_idle_busy", 32'(busy), 32'd0);
    tick(); sample();
    chk("p_wl_write", 32'(bus.avm_write), 32'd1);
    chk("p_wl_addr", 32'(bus.avm_address), 32'd2);
    chk("p_wl_data", bus.avm_writedata, 32'h00001234);
    chk("p_wl_ready", 32'(bus.play_ready), 32'd0);
    tick(); sample();
    chk("p_wr_write", 32'(bus.avm_write), 32'd1);
    chk("p_wr_addr", 32'(bus.avm_address), 32'd3);
    chk("p_wr_data", bus.avm_writedata, 32'h0000ABCD);
    chk("p_wr_ready", 32'(bus.play_ready), 32'd1);
    tick(); bus.play_valid = 1'b0; sample();
    chk("p_done_busy", 32'(busy), 32'd0);
    chk("p_done_ready", 32'(bus.play_ready), 32'd0);
    chk("p_done_count", 32'(play_count), 32'd1);

    // ---------------- record pair and output hold ----------------
    do_reset();
    enable = 1'b1; space_in = 16'h0003; bus.avm_readdata = 32'hDEAD0000;
    sample();
    tick(); sample();
    chk("r_rl_read", 32'(bus.avm_read), 32'd1);
    chk("r_rl_addr", 32'(bus.avm_address), 32'd2);
    chk("r_rl_write", 32'(bus.avm_write), 32'd0);
    tick(); bus.avm_readdata = 32'h00005555; sample();
    chk("r_rld_read", 32'(bus.avm_read), 32'd0);
    tick(); bus.avm_readdata = 32'hBEEF1111; sample();
    chk("r_rr_read", 32'(bus.avm_read), 32'd1);
    chk("r_rr_addr", 32'(bus.avm_address), 32'd3);
    tick(); bus.avm_readdata = 32'h0000AAAA; sample();
    chk("r_rrd_busy", 32'(busy), 32'd1);
    chk("r_rrd_valid", 32'(bus.rec_valid), 32'd0);
    tick(); bus.avm_readdata = 32'h12345678; sample();
    chk("r_valid", 32'(bus.rec_valid), 32'd1);
    chk("r_data", bus.rec_data, 32'h5555AAAA);
    chk("r_count", 32'(rec_count), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick(); sample();
      chk("r_hold_valid", 32'(bus.rec_valid), 32'd1);
      chk("r_hold_data", bus.rec_data, 32'h5555AAAA);
      chk("r_hold_stall", 32'(busy), 32'd0);
    end
    tick(); bus.rec_ready = 1'b1; sample();
    chk("r_ready_valid", 32'(bus.rec_valid), 32'd1);
    tick(); bus.rec_ready = 1'b0; enable = 1'b0; sample();
    chk("r_cleared", 32'(bus.rec_valid), 32'd0);

    // ---------------- waitrequest held 3 cycles in WL ----------------
    do_reset();
    enable = 1'b1; bus.play_valid = 1'b1; bus.play_data = 32'hCAFE0BEE; space_in = 16'h0100;
    bus.avm_waitrequest = 1'b1;
    sample();
    tick();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("w_stall_write", 32'(bus.avm_write), 32'd1);
      chk("w_stall_addr", 32'(bus.avm_address), 32'd2);
      chk("w_stall_data", bus.avm_writedata, 32'h0000CAFE);
      tick();
    end
    bus.avm_waitrequest = 1'b0;
    sample();
    chk("w_accept_addr", 32'(bus.avm_address), 32'd2);
    tick(); sample();
    chk("w_wr_addr", 32'(bus.avm_address), 32'd3);
    chk("w_wr_data", bus.avm_writedata, 32'h00000BEE);
    chk("w_wr_ready", 32'(bus.play_ready), 32'd1);
    tick(); bus.play_valid = 1'b0; sample();
    chk("w_done_count", 32'(play_count), 32'd1);
    chk("w_done_busy", 32'(busy), 32'd0);

    // ---------------- no write space; reset in RR ----------------
    do_reset();
    enable = 1'b1; bus.play_valid = 1'b1; bus.play_data = 32'h11112222; space_in = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("nospace_write", 32'(bus.avm_write), 32'd0);
      chk("nospace_busy", 32'(busy), 32'd0);
      tick();
    end
    space_in = 16'h0101;
    sample();                       // IDLE: play granted
    tick(); sample();               // WL
    tick(); sample();               // WR
    tick(); sample();               // IDLE: record granted (play went last)
    chk("rst_pre_count", 32'(play_count), 32'd1);
    tick(); sample();
    chk("rst_rl_read", 32'(bus.avm_read), 32'd1);
    tick(); sample();               // RLD
    tick(); bus.avm_waitrequest = 1'b1; sample();
    chk("rst_rr_read", 32'(bus.avm_read), 32'd1);
    chk("rst_rr_addr", 32'(bus.avm_address), 32'd3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; enable = 1'b0; bus.avm_waitrequest = 1'b0;
    sample();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read", 32'(bus.avm_read), 32'd0);
    chk("rst_rec_valid", 32'(bus.rec_valid), 32'd0);
    chk("rst_counts", {play_count, rec_count}, 32'd0);
    tick(); sample();
    chk("rst_after_valid", 32'(bus.rec_valid), 32'd0);

    // ---------------- round-robin alternation, then record stall ----------------
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      enable = 1'b1; bus.play_valid = 1'b1; bus.play_data = 32'h0F0F3C3C; space_in = 16'h0101;
      bus.rec_ready = (phase == 0);
      grants.delete();
      prev_busy = 1'b0;
      for (int k = 0; k < 40; k++) begin
        sample();
        if (busy && !prev_busy) grants.push_back(bus.avm_write);
        prev_busy = busy;
        tick();
      end
      if (grants.size() < 5) begin
        checks++; failures++;
        $display("FAIL rr_grant_count actual=%0d required=5", grants.size());
      end else if (phase == 0) begin
        for (int g = 0; g < 4; g++) chk("rr_alternate", 32'(grants[g]), 32'((g % 2) == 0));
      end else begin
        chk("rr_stall_g0", 32'(grants[0]), 32'd1);
        chk("rr_stall_g1", 32'(grants[1]), 32'd0);
        for (int g = 2; g < 5; g++) chk("rr_stall_play", 32'(grants[g]), 32'd1);
        chk("rr_stall_valid", 32'(bus.rec_valid), 32'd1);
        chk("rr_stall_rcount", 32'(rec_count), 32'd1);
      end
    end

    // ---------------- play_count wrap (counter fast-forwarded to 0xFFFF) ----------------
    do_reset();
    force dut.play_count_q = 16'hFFFF;
    sample();
    release dut.play_count_q;
    tick();
    enable = 1'b1; bus.play_valid = 1'b1; bus.play_data = 32'hA5A55A5A; space_in = 16'h0100;
    sample();
    chk("wrap_pre", 32'(play_count), 32'h0000FFFF);
    tick(); sample();
    tick(); sample();
    tick(); bus.play_valid = 1'b0; sample();
    chk("wrap_zero", 32'(play_count), 32'd0);
    tick(); bus.play_valid = 1'b1; sample();
    tick(); sample();
    tick(); sample();
    tick(); bus.play_valid = 1'b0; sample();
    chk("wrap_one", 32'(play_count), 32'd1);

    // ---------------- randomized run against a transaction model ----------------
    do_reset();
    last_rec = 1'b1; exp_g = 0; w_half = 1'b0; r_half = 1'b0; rd_pend = 1'b0;
    play_taken = 1'b0; plays_done = 0; recs_done = 0; pair_q.delete();
    rd_next = 32'h0; left_tmp = 16'h0;
    for (int n = 0; n < 4000; n++) begin
      bus.avm_readdata = rd_pend ? rd_next : $urandom();
      rd_pend = 1'b0;
      enable = ($urandom_range(0, 7) != 0);
      if (!bus.play_valid || play_taken) begin
        bus.play_valid = ($urandom_range(0, 3) != 0);
        bus.play_data  = $urandom();
      end
      play_taken = 1'b0;
      space_in = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))};
      bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
      bus.rec_ready = 1'($urandom_range(0, 1));
      sample();

      if (exp_g != 0) begin
        chk("rnd_grant_busy", 32'(busy), 32'(exp_g != 3));
        chk("rnd_grant_write", 32'(bus.avm_write), 32'(exp_g == 1));
        chk("rnd_grant_read", 32'(bus.avm_read), 32'(exp_g == 2));
        exp_g = 0;
      end
      chk("rnd_rw_exclusive", 32'(bus.avm_read & bus.avm_write), 32'd0);

      if (!busy) begin
        chk("rnd_play_count", 32'(play_count), 32'(plays_done[15:0]));
        chk("rnd_rec_count", 32'(rec_count), 32'(recs_done[15:0]));
        pe = enable && bus.play_valid && (space_in[15:8] >= 8'd1);
        re = enable && (space_in[7:0] >= 8'd1) && !bus.rec_valid;
        if (pe && (!re || last_rec)) begin exp_g = 1; last_rec = 1'b0; end
        else if (re)                 begin exp_g = 2; last_rec = 1'b1; end
        else                               exp_g = 3;
      end

      if (bus.avm_write && !bus.avm_waitrequest) begin
        if (!w_half) begin
          chk("rnd_wl_addr", 32'(bus.avm_address), 32'd2);
          chk("rnd_wl_data", bus.avm_writedata, {16'h0, bus.play_data[31:16]});
          chk("rnd_wl_ready", 32'(bus.play_ready), 32'd0);
          w_half = 1'b1;
        end else begin
          chk("rnd_wr_addr", 32'(bus.avm_address), 32'd3);
          chk("rnd_wr_data", bus.avm_writedata, {16'h0, bus.play_data[15:0]});
          chk("rnd_wr_ready", 32'(bus.play_ready), 32'd1);
          plays_done++;
          play_taken = 1'b1;
          w_half = 1'b0;
        end
      end else begin
        chk("rnd_ready_idle", 32'(bus.play_ready), 32'd0);
      end

      if (bus.avm_read && !bus.avm_waitrequest) begin
        rd_next = $urandom();
        rd_pend = 1'b1;
        if (!r_half) begin
          chk("rnd_rl_addr", 32'(bus.avm_address), 32'd2);
          left_tmp = rd_next[15:0];
          r_half = 1'b1;
        end else begin
          chk("rnd_rr_addr", 32'(bus.avm_address), 32'd3);
          pair_q.push_back({left_tmp, rd_next[15:0]});
          recs_done++;
          r_half = 1'b0;
        end
      end

      if (bus.rec_valid && bus.rec_ready) begin
        if (pair_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rnd_rec_spurious actual=%h required=none", bus.rec_data);
        end else begin
          exp_pair = pair_q.pop_front();
          chk("rnd_rec_data", bus.rec_data, exp_pair);
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_xfer_sched.md
AUDIO_XFER_SCHED -- requirements
Module: audio_xfer_sched

Interface
REQ-001 SHALL have parameter ADDR_LEFT, default 2, audio core left-channel data register word address.
REQ-002 SHALL have parameter ADDR_RIGHT, default 3, audio core right-channel data register word address.
REQ-003 SHALL have parameter MIN_SPACE, default 1, minimum FIFO count (8-bit) for a channel to be eligible.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, scheduler run enable.
REQ-007 SHALL have port space_in, input, 16: [15:8] wspace, free playback FIFO words; [7:0] ravail, record FIFO samples available.
REQ-008 SHALL have ports play_valid (in, 1), play_data (in, 32, {left[31:16], right[15:0]}), and play_ready (out, 1), the playback source stream.
REQ-009 SHALL have ports rec_valid (out, 1), rec_data (out, 32, {left[31:16], right[15:0]}), and rec_ready (in, 1), the record sink stream.
REQ-010 SHALL have ports avm_address (out, 2), avm_read (out, 1), avm_write (out, 1), avm_writedata (out, 32), avm_readdata (in, 32), and avm_waitrequest (in, 1), the Avalon master to the audio core.
REQ-011 SHALL have ports play_count (out, 16) and rec_count (out, 16), completed stereo-pair counters.
REQ-012 SHALL have port busy (out, 1), high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, WL, WR, RL, RLD, RR, RRD.
REQ-014 SHALL deem playback eligible in IDLE when enable=1, play_valid=1 and wspace>=MIN_SPACE.
REQ-015 SHALL deem record eligible in IDLE when enable=1, ravail>=MIN_SPACE and rec_valid=0.
REQ-016 SHALL arbitrate round-robin between the two channels: when both are eligible, the channel not granted last wins; the first grant after reset goes to playback.
REQ-017 SHALL, on a playback grant, latch play_data into an internal register and go IDLE->WL in the same edge.
REQ-018 SHALL, in WL, drive avm_write=1, avm_address=ADDR_LEFT, avm_writedata={16'b0,left}, and go to WR on the first cycle with avm_waitrequest=0.
REQ-019 SHALL, in WR, drive avm_write=1, avm_address=ADDR_RIGHT, avm_writedata={16'b0,right}; when avm_waitrequest=0, pulse play_ready for exactly that cycle, increment play_count, and go to IDLE.
REQ-020 SHALL, on a record grant, go IDLE->RL.
REQ-021 SHALL, in RL, drive avm_read=1, avm_address=ADDR_LEFT, and go to RLD when avm_waitrequest=0.
REQ-022 SHALL, in RLD, capture avm_readdata[15:0] as the left sample (read data is valid the cycle after acceptance) and go to RR.
REQ-023 SHALL handle RR/RRD the same way at ADDR_RIGHT; in RRD it SHALL load rec_data={left,avm_readdata[15:0]}, set rec_valid=1, increment rec_count, and go to IDLE.
REQ-024 SHALL hold rec_valid and rec_data stable until the cycle rec_ready=1, then clear rec_valid at the next edge.
REQ-025 SHALL drive avm_read and avm_write low, and never assert both, outside the states named above.
REQ-026 SHALL keep avm_address and avm_writedata stable while avm_waitrequest=1.
REQ-027 SHALL, if enable is deasserted mid-pair, complete the current stereo pair, then remain in IDLE.
REQ-028 SHALL wrap play_count and rec_count from 0xFFFF to 0x0000.
REQ-029 SHALL sample space_in only in IDLE; space changes during a pair SHALL NOT affect the pair.

Reset
REQ-030 SHALL, with reset_n=0 at a clock edge, go to IDLE, set the last-grant record to "record" so that playback wins next, and clear play_ready, rec_valid, rec_data, avm_read, avm_write, avm_address, avm_writedata, play_count, rec_count and busy to 0.
REQ-031 SHALL abort any in-flight transfer on reset without issuing a play_ready pulse or a count increment.

Verification
REQ-032 SHALL cover: enable=1, play_valid=1, play_data=0x1234ABCD, space_in=0x0400, no waitrequest -> write 0x1234 to addr 2, then write 0xABCD to addr 3 on consecutive cycles, one play_ready pulse, play_count=1.
REQ-033 SHALL cover: space_in=0x0003, avm_readdata 0x00005555 then 0x0000AAAA -> rec_data=0x5555AAAA, rec_valid=1 held until rec_ready, rec_count=1.
REQ-034 SHALL cover: both channels continuously eligible -> grants alternate play, rec, play, rec, and record stalls while rec_valid=1 and rec_ready=0.
REQ-035 SHALL cover: avm_waitrequest=1 for 3 cycles in WL -> address/data held, no state advance, then normal completion.
REQ-036 SHALL cover: wspace=0 with play_valid=1 -> no write issued; reset_n=0 asserted in RR -> IDLE next edge, counters 0, no rec_valid.
REQ-037 SHALL cover: play_count preset via 65535 pairs -> next pair wraps play_count to 0.
